// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD stopwatch/countdown controller.
// Prescaled run/pause/done sequencing with a wrap/expire pulse.
module bcd_timer_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int PW       = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  input  logic       LOAD,
  input  logic       DIR,
  input  logic [3:0] PRESET_TENS,
  input  logic [3:0] PRESET_ONES,
  output logic [3:0] CNT_TENS,
  output logic [3:0] CNT_ONES,
  output logic       RUNNING,
  output logic       DONE,
  output logic       CR,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          cr_q, cr_d;
  logic [3:0]    pt_clamp, po_clamp;
  logic          tick;
  logic          cnt_zero;

  assign pt_clamp = (PRESET_TENS > 4'd9) ? 4'd9 : PRESET_TENS;
  assign po_clamp = (PRESET_ONES > 4'd9) ? 4'd9 : PRESET_ONES;
  assign tick     = (pre_q == PRE_LAST);
  assign cnt_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // State, count and prescaler registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      pre_q   <= '0;
      cr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pre_q   <= pre_d;
      cr_q    <= cr_d;
    end
  end

  // Command priority, prescaler advance and BCD step
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pre_d   = pre_q;
    cr_d    = 1'b0;
    if (CLEAR) begin
      state_d = S_IDLE;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      pre_d   = '0;
    end else if (LOAD) begin
      state_d = S_IDLE;
      tens_d  = pt_clamp;
      ones_d  = po_clamp;
      pre_d   = '0;
    end else if (STOP) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (START && state_q == S_IDLE) begin
      if (DIR && cnt_zero) begin
        state_d = S_DONE;
      end else begin
        state_d = S_RUN;
        pre_d   = '0;
      end
    end else if (START && state_q == S_PAUSE) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (!tick) begin
        pre_d = pre_q + PW'(1);
      end else begin
        pre_d = '0;
        if (!DIR) begin
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            if (tens_q == 4'd9) begin
              tens_d = 4'd0;
              cr_d   = 1'b1;
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else if (tens_q == 4'd0 && ones_q <= 4'd1) begin
          ones_d  = 4'd0;
          state_d = S_DONE;
          cr_d    = 1'b1;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  assign CNT_TENS = tens_q;
  assign CNT_ONES = ones_q;
  assign RUNNING  = (state_q == S_RUN);
  assign DONE     = (state_q == S_DONE);
  assign CR       = cr_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: directed vector table, hand sequences,
// and random commands checked against an integer-count model.
module tb_bcd_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, load, dir;
  logic [3:0] pt, po;
  logic [3:0] cnt_tens, cnt_ones;
  logic       running, done, cr;
  logic [1:0] state;

  int n_pass = 0;
  int n_total = 0;

  bcd_timer_ctrl #(.TICK_DIV(4), .PW(16)) dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop),
    .CLEAR(clear), .LOAD(load), .DIR(dir),
    .PRESET_TENS(pt), .PRESET_ONES(po),
    .CNT_TENS(cnt_tens), .CNT_ONES(cnt_ones),
    .RUNNING(running), .DONE(done), .CR(cr), .STATE(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, sp, cl, ld, dir;
    logic [3:0] pt, po;
    logic [3:0] et, eo;
    logic [1:0] es;
    logic       ecr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic p, logic c,
                              logic l, logic d, logic [3:0] a,
                              logic [3:0] b, logic [3:0] et,
                              logic [3:0] eo, logic [1:0] es,
                              logic ecr);
    vec_t v;
    v.rst = r; v.st = s; v.sp = p; v.cl = c; v.ld = l; v.dir = d;
    v.pt = a; v.po = b; v.et = et; v.eo = eo; v.es = es; v.ecr = ecr;
    return v;
  endfunction

  function automatic logic [14:0] pack(logic [3:0] t, logic [3:0] o,
                                       logic [1:0] s, logic c);
    return {t, o, s == 2'b01, s == 2'b11, c, s};
  endfunction

  function automatic logic [14:0] actual();
    return {cnt_tens, cnt_ones, running, done, cr, state};
  endfunction

  task automatic drive(logic r, logic s, logic p, logic c, logic l,
                       logic d, logic [3:0] a, logic [3:0] b);
    rst = r; start = s; stop = p; clear = c; load = l; dir = d;
    pt = a; po = b;
  endtask

  task automatic check(string nm, logic [14:0] got, logic [14:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got t/o=%h%h run=%b done=%b cr=%b st=%b, want t/o=%h%h run=%b done=%b cr=%b st=%b",
                  nm, got[14:11], got[10:7], got[6], got[5], got[4], got[3:0],
                  exp[14:11], exp[10:7], exp[6], exp[5], exp[4], exp[3:0]);
  endtask

  task automatic step_chk(string nm, logic [3:0] et, logic [3:0] eo,
                          logic [1:0] es, logic ecr);
    @(posedge clk);
    #1;
    check(nm, actual(), pack(et, eo, es, ecr));
  endtask

  // Reference model: count as an integer 0..99, phase as an integer
  int m_st, m_cnt, m_pre, m_cr;

  task automatic model_step();
    int ncr;
    ncr = 0;
    if (!rst) begin
      m_st = 0; m_cnt = 0; m_pre = 0;
    end else if (clear) begin
      m_st = 0; m_cnt = 0; m_pre = 0;
    end else if (load) begin
      m_cnt = ((pt > 9) ? 9 : int'(pt)) * 10 + ((po > 9) ? 9 : int'(po));
      m_st = 0; m_pre = 0;
    end else if (stop) begin
      if (m_st == 1) m_st = 2;
    end else if (start && m_st == 0) begin
      if (dir && m_cnt == 0) m_st = 3;
      else begin m_st = 1; m_pre = 0; end
    end else if (start && m_st == 2) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (m_pre == 3) begin
        m_pre = 0;
        if (!dir) begin
          m_cnt = (m_cnt + 1) % 100;
          if (m_cnt == 0) ncr = 1;
        end else if (m_cnt <= 1) begin
          m_cnt = 0; m_st = 3; ncr = 1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    m_cr = ncr;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // reset and basic up count
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,2'b00,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,2'b00,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 0,0,2'b01,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,2'b01,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,2'b01,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,2'b01,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,2,2'b01,0));
    // up wrap 98 -> 99 -> 00 with CR
    tbl.push_back(mk(1,0,0,0,1,0,9,8, 9,8,2'b00,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 9,8,2'b01,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 9,8,2'b01,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 9,9,2'b01,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 9,9,2'b01,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,2'b01,1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,2'b01,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,2'b01,0));
    // countdown 02 -> 01 -> 00 expire
    tbl.push_back(mk(1,0,0,0,1,0,0,2, 0,2,2'b00,0));
    tbl.push_back(mk(1,1,0,0,0,1,0,0, 0,2,2'b01,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,1,0,0, 0,2,2'b01,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0,1,2'b01,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,1,0,0, 0,1,2'b01,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0,0,2'b11,1));
    tbl.push_back(mk(1,1,0,0,0,1,0,0, 0,0,2'b11,0));
    tbl.push_back(mk(1,0,0,1,0,1,0,0, 0,0,2'b00,0));
    // priority and clamping
    tbl.push_back(mk(1,0,0,0,1,0,3,7, 3,7,2'b00,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 3,7,2'b01,0));
    tbl.push_back(mk(1,1,1,1,0,0,0,0, 0,0,2'b00,0));
    tbl.push_back(mk(1,0,0,0,1,0,4'hC,5, 9,5,2'b00,0));
    tbl.push_back(mk(1,0,0,0,1,0,4'hF,3, 9,3,2'b00,0));
    tbl.push_back(mk(1,1,1,0,0,0,0,0, 9,3,2'b00,0));
    tbl.push_back(mk(1,0,0,1,0,0,0,0, 0,0,2'b00,0));
    tbl.push_back(mk(1,1,0,0,0,1,0,0, 0,0,2'b11,0));
    // reset on the would-be wrap tick
    tbl.push_back(mk(1,0,0,0,1,0,9,9, 9,9,2'b00,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 9,9,2'b01,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 9,9,2'b01,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,2'b00,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,2'b00,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].ld,
            tbl[i].dir, tbl[i].pt, tbl[i].po);
      step_chk($sformatf("row%0d", i), tbl[i].et, tbl[i].eo,
               tbl[i].es, tbl[i].ecr);
    end

    // pause keeps prescaler phase
    drive(1,0,0,1,0,0,0,0); step_chk("ph_clr", 0,0,2'b00,0);
    drive(1,1,0,0,0,0,0,0); step_chk("ph_go", 0,0,2'b01,0);
    drive(1,0,0,0,0,0,0,0); step_chk("ph_p1", 0,0,2'b01,0);
    step_chk("ph_p2", 0,0,2'b01,0);
    drive(1,0,1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) step_chk("ph_stop", 0,0,2'b10,0);
    drive(1,1,0,0,0,0,0,0); step_chk("ph_resume", 0,0,2'b01,0);
    drive(1,0,0,0,0,0,0,0); step_chk("ph_r1", 0,0,2'b01,0);
    step_chk("ph_r2_step", 0,1,2'b01,0);
    // stop on the tick cycle
    for (int i = 0; i < 3; i++) step_chk("tk_run", 0,1,2'b01,0);
    drive(1,0,1,0,0,0,0,0); step_chk("tk_stop", 0,1,2'b10,0);
    drive(1,0,0,0,0,0,0,0); step_chk("tk_hold", 0,1,2'b10,0);
    drive(1,1,0,0,0,0,0,0); step_chk("tk_resume", 0,1,2'b01,0);
    drive(1,0,0,0,0,0,0,0); step_chk("tk_step", 0,2,2'b01,0);

    // DIR flipped to down while running at 00
    drive(1,0,0,0,1,0,9,9); step_chk("z_load", 9,9,2'b00,0);
    drive(1,1,0,0,0,0,0,0); step_chk("z_go", 9,9,2'b01,0);
    drive(1,0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) step_chk("z_wait", 9,9,2'b01,0);
    step_chk("z_wrap", 0,0,2'b01,1);
    drive(1,0,0,0,0,1,0,0);
    for (int i = 0; i < 3; i++) step_chk("z_down", 0,0,2'b01,0);
    step_chk("z_expire", 0,0,2'b11,1);
    step_chk("z_hold", 0,0,2'b11,0);

    // random commands against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      clear = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      pt = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      po = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      model_step();
      check($sformatf("rand%0d", i), actual(),
            pack(4'(m_cnt / 10), 4'(m_cnt % 10), 2'(m_st), m_cr[0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
